// File: rtl/hex_pkg.sv
// Shared types for the memory-side blocks: word address/data types and the
// data-port arbiter's state and requester encodings.
package hex_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] waddr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ARB_S,
    LOCK_S,
    CSLOT_S
  } arb_state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_LDR
  } arb_req_t;

endpackage

// File: rtl/arb_rsp_reg.sv
// Per-requester read-response register: captures memory read data on an
// accepted read and pulses rvalid for exactly one cycle afterwards.
module arb_rsp_reg
  import hex_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_capture,
  input  data_t i_data,
  output logic  o_rvalid,
  output data_t o_rdata
);

  logic  r_rvalid;
  data_t r_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_capture;
      if (i_capture) begin
        r_rdata <= i_data;
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / loader) arbiter for the memory data port with loader
// burst locking and forced CPU slots. Define HEX_ARB_ROUND_ROBIN_EN for round-robin ties in ARB.
module mem_port_arbiter
  import hex_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_c_valid,
  input  logic   i_c_we,
  input  waddr_t i_c_addr,
  input  data_t  i_c_data,
  output logic   o_c_ready,
  output logic   o_c_rvalid,
  output data_t  o_c_rdata,
  input  logic   i_l_valid,
  input  logic   i_l_we,
  input  waddr_t i_l_addr,
  input  data_t  i_l_data,
  input  logic   i_l_lock,
  output logic   o_l_ready,
  output logic   o_l_rvalid,
  output data_t  o_l_rdata,
  output logic   o_m_valid,
  output logic   o_m_we,
  output waddr_t o_m_addr,
  output data_t  o_m_data,
  input  data_t  i_m_data
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_c_gnt;
  logic             w_l_gnt;
  logic             w_cpu_first;

`ifdef HEX_ARB_ROUND_ROBIN_EN
  arb_req_t r_last;

  // Starts as "loader" so the first tie after reset goes to the CPU.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last <= REQ_LDR;
    end else if (w_c_gnt) begin
      r_last <= REQ_CPU;
    end else if (w_l_gnt) begin
      r_last <= REQ_LDR;
    end
  end

  assign w_cpu_first = (r_last == REQ_LDR);
`else
  assign w_cpu_first = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ARB_S;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_c_gnt     = 1'b0;
    w_l_gnt     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB_S: begin
        if (i_c_valid && (!i_l_valid || w_cpu_first)) begin
          w_c_gnt = 1'b1;
        end else if (i_l_valid) begin
          w_l_gnt = 1'b1;
          if (i_l_lock) begin
            w_state_nxt = LOCK_S;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      LOCK_S: begin
        // The forced CPU slot is decided before any loader grant this cycle.
        if ((r_cnt == MAX_CNT) && i_c_valid) begin
          w_state_nxt = CSLOT_S;
        end else if (i_l_valid) begin
          w_l_gnt = 1'b1;
          if (i_l_lock) begin
            w_cnt_nxt = (r_cnt == MAX_CNT) ? r_cnt : r_cnt + 1'b1;
          end else begin
            w_state_nxt = ARB_S;
            w_cnt_nxt   = '0;
          end
        end else if (!i_l_lock) begin
          w_state_nxt = ARB_S;
          w_cnt_nxt   = '0;
        end
      end
      CSLOT_S: begin
        w_c_gnt     = i_c_valid;
        w_state_nxt = i_l_lock ? LOCK_S : ARB_S;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ARB_S;
        w_cnt_nxt   = '0;
      end
    endcase
    if (!i_rst_n) begin
      w_c_gnt = 1'b0;
      w_l_gnt = 1'b0;
    end
  end

  assign o_c_ready = w_c_gnt;
  assign o_l_ready = w_l_gnt;
  assign o_m_valid = w_c_gnt | w_l_gnt;
  assign o_m_we    = (w_c_gnt & i_c_we) | (w_l_gnt & i_l_we);
  assign o_m_addr  = w_l_gnt ? i_l_addr : i_c_addr;
  assign o_m_data  = w_l_gnt ? i_l_data : i_c_data;

  arb_rsp_reg u_c_rsp (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_capture (w_c_gnt & ~i_c_we),
    .i_data    (i_m_data),
    .o_rvalid  (o_c_rvalid),
    .o_rdata   (o_c_rdata)
  );

  arb_rsp_reg u_l_rsp (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_capture (w_l_gnt & ~i_l_we),
    .i_data    (i_m_data),
    .o_rvalid  (o_l_rvalid),
    .o_rdata   (o_l_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// lock/CSLOT/reset sequences and random traffic against a shadow memory.
module tb_mem_port_arbiter;
  import hex_pkg::*;

  logic   i_clk = 1'b0;
  logic   i_rst_n;
  logic   i_c_valid, i_c_we, i_l_valid, i_l_we, i_l_lock;
  waddr_t i_c_addr, i_l_addr;
  data_t  i_c_data, i_l_data;
  logic   o_c_ready, o_c_rvalid, o_l_ready, o_l_rvalid;
  data_t  o_c_rdata, o_l_rdata;
  logic   o_m_valid, o_m_we;
  waddr_t o_m_addr;
  data_t  o_m_data, i_m_data;

  int total = 0;
  int bad   = 0;

  data_t mem [0:1023];

  always #5 i_clk = ~i_clk;

  mem_port_arbiter dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_c_valid  (i_c_valid),
    .i_c_we     (i_c_we),
    .i_c_addr   (i_c_addr),
    .i_c_data   (i_c_data),
    .o_c_ready  (o_c_ready),
    .o_c_rvalid (o_c_rvalid),
    .o_c_rdata  (o_c_rdata),
    .i_l_valid  (i_l_valid),
    .i_l_we     (i_l_we),
    .i_l_addr   (i_l_addr),
    .i_l_data   (i_l_data),
    .i_l_lock   (i_l_lock),
    .o_l_ready  (o_l_ready),
    .o_l_rvalid (o_l_rvalid),
    .o_l_rdata  (o_l_rdata),
    .o_m_valid  (o_m_valid),
    .o_m_we     (o_m_we),
    .o_m_addr   (o_m_addr),
    .o_m_data   (o_m_data),
    .i_m_data   (i_m_data)
  );

  function automatic data_t initVal(input int a);
    return data_t'(32'h1000 + a * 3);
  endfunction

  // Memory model: combinational read, write commits at the accepting edge.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = initVal(i);
    forever begin
      @(posedge i_clk);
      if (o_m_valid && o_m_we) mem[o_m_addr] <= o_m_data;
    end
  end

  assign i_m_data = mem[o_m_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic cv, input logic cwe, input waddr_t ca, input data_t cd,
                               input logic lv, input logic lwe, input waddr_t la, input data_t ld,
                               input logic lk);
    i_c_valid = cv;
    i_c_we    = cwe;
    i_c_addr  = ca;
    i_c_data  = cd;
    i_l_valid = lv;
    i_l_we    = lwe;
    i_l_addr  = la;
    i_l_data  = ld;
    i_l_lock  = lk;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic resetDut;
    i_rst_n = 1'b0;
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
    tick();
    i_rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic cv, cwe, lv, lwe;
    logic expC, expL, expMv, expMwe;
    waddr_t expAddr;
  } vec_t;

  vec_t vecs [6];
  logic expC2 [4];

  int     lb;
  logic   cDone;
  logic   cPend, lPend, cWe, lWe, lLk;
  waddr_t cA, lA;
  data_t  cD, lD;
  logic   expCrv, expLrv;
  data_t  expCd, expLd;
  data_t  shadow [16];
  int     genC, genL, accC, accL, waitC, waitL;

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 10'd0};
    vecs[1] = '{1, 1, 0, 0, 1, 0, 1, 1, 10'd7};
    vecs[2] = '{1, 0, 0, 0, 1, 0, 1, 0, 10'd7};
    vecs[3] = '{0, 0, 1, 1, 0, 1, 1, 1, 10'd9};
    vecs[4] = '{0, 0, 1, 0, 0, 1, 1, 0, 10'd9};
    vecs[5] = '{0, 1, 0, 1, 0, 0, 0, 0, 10'd0};
`ifdef HEX_ARB_ROUND_ROBIN_EN
    expC2 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    expC2 = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset: grants forced low while held, response registers cleared.
    i_rst_n = 1'b0;
    applyStimulus(1, 0, 10'd1, '0, 1, 0, 10'd2, '0, 0);
    @(negedge i_clk);
    checkFlag("rst c_ready", o_c_ready, 0);
    checkFlag("rst l_ready", o_l_ready, 0);
    checkFlag("rst m_valid", o_m_valid, 0);
    tick();
    @(negedge i_clk);
    checkFlag("rst c_rvalid", o_c_rvalid, 0);
    checkFlag("rst l_rvalid", o_l_rvalid, 0);
    checkOutput("rst c_rdata", o_c_rdata, 32'h0);
    checkOutput("rst l_rdata", o_l_rdata, 32'h0);
    tick();
    i_rst_n = 1'b1;

    $display("[TB] test 1: CPU write then read");
    applyStimulus(1, 1, 10'd5, 32'hDEADBEEF, 0, 0, '0, '0, 0);
    @(negedge i_clk);
    checkFlag("t1 wr ready", o_c_ready, 1);
    checkFlag("t1 wr m_we", o_m_we, 1);
    checkOutput("t1 wr m_addr", 32'(o_m_addr), 32'd5);
    tick();
    applyStimulus(1, 0, 10'd5, '0, 0, 0, '0, '0, 0);
    @(negedge i_clk);
    checkFlag("t1 rd ready", o_c_ready, 1);
    checkFlag("t1 rd m_we", o_m_we, 0);
    tick();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
    @(negedge i_clk);
    checkFlag("t1 rvalid", o_c_rvalid, 1);
    checkOutput("t1 rdata", o_c_rdata, 32'hDEADBEEF);
    checkFlag("t1 l_rvalid", o_l_rvalid, 0);
    tick();
    @(negedge i_clk);
    checkFlag("t1 rvalid drop", o_c_rvalid, 0);
    checkOutput("t1 rdata hold", o_c_rdata, 32'hDEADBEEF);
    tick();

    $display("[TB] vector table in ARB");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].cv, vecs[v].cwe, 10'd7, 32'h77, vecs[v].lv, vecs[v].lwe, 10'd9, 32'h99, 0);
      @(negedge i_clk);
      checkFlag($sformatf("vec%0d c_ready", v), o_c_ready, vecs[v].expC);
      checkFlag($sformatf("vec%0d l_ready", v), o_l_ready, vecs[v].expL);
      checkFlag($sformatf("vec%0d m_valid", v), o_m_valid, vecs[v].expMv);
      checkFlag($sformatf("vec%0d m_we", v), o_m_we, vecs[v].expMwe);
      if (vecs[v].expMv) checkOutput($sformatf("vec%0d m_addr", v), 32'(o_m_addr), 32'(vecs[v].expAddr));
      tick();
    end

    $display("[TB] test 2: contention in ARB");
    resetDut();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) applyStimulus(1, 0, 10'd1, '0, 1, 0, 10'd2, '0, 0);
      else       applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
      @(negedge i_clk);
      if (k < 4) begin
        checkFlag($sformatf("t2 c_ready k%0d", k), o_c_ready, expC2[k]);
        checkFlag($sformatf("t2 l_ready k%0d", k), o_l_ready, !expC2[k]);
      end
      if (k > 0) begin
        checkFlag($sformatf("t2 c_rvalid k%0d", k), o_c_rvalid, expC2[k-1]);
        checkFlag($sformatf("t2 l_rvalid k%0d", k), o_l_rvalid, !expC2[k-1]);
        if (expC2[k-1]) checkOutput($sformatf("t2 c_rdata k%0d", k), o_c_rdata, 32'h1003);
        else            checkOutput($sformatf("t2 l_rdata k%0d", k), o_l_rdata, 32'h1006);
      end
      tick();
    end

    $display("[TB] test 3: locked burst with forced CPU slot");
    lb = 0;
    cDone = 1'b0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus((k >= 2) && !cDone, 0, 10'd100, '0,
                    lb < 12, 1, waddr_t'(100 + lb), data_t'(32'hA0 + lb), lb < 11);
      @(negedge i_clk);
      checkFlag($sformatf("t3 l_ready k%0d", k), o_l_ready, (k <= 7) || (k >= 10));
      checkFlag($sformatf("t3 c_ready k%0d", k), o_c_ready, k == 9);
      if (k == 10) begin
        checkFlag("t3 c_rvalid", o_c_rvalid, 1);
        checkOutput("t3 c_rdata", o_c_rdata, 32'hA0);
      end
      if (o_l_ready) lb++;
      if (o_c_ready) cDone = 1'b1;
      tick();
    end
    checkOutput("t3 loader beats", lb, 12);

    $display("[TB] test 4: idle locked loader holds the port");
    applyStimulus(0, 0, '0, '0, 1, 1, 10'd50, 32'h55, 1);
    @(negedge i_clk);
    checkFlag("t4 lock beat", o_l_ready, 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 10'd5, '0, 0, 0, '0, '0, 1);
      @(negedge i_clk);
      checkFlag($sformatf("t4 c held k%0d", k), o_c_ready, 0);
      tick();
    end
    applyStimulus(1, 0, 10'd5, '0, 0, 0, '0, '0, 0);
    @(negedge i_clk);
    checkFlag("t4 c unlock cycle", o_c_ready, 0);
    tick();
    @(negedge i_clk);
    checkFlag("t4 c granted", o_c_ready, 1);
    tick();

    $display("[TB] test 5: reset mid-burst");
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, '0, '0, 1, 0, waddr_t'(100 + k), '0, 1);
      @(negedge i_clk);
      checkFlag($sformatf("t5 l_ready k%0d", k), o_l_ready, 1);
      tick();
    end
    i_rst_n = 1'b0;
    applyStimulus(1, 0, 10'd5, '0, 1, 0, 10'd103, '0, 1);
    @(negedge i_clk);
    checkFlag("t5 c_ready in rst", o_c_ready, 0);
    checkFlag("t5 l_ready in rst", o_l_ready, 0);
    checkFlag("t5 m_valid in rst", o_m_valid, 0);
    checkFlag("t5 in-flight rvalid", o_l_rvalid, 1);
    checkOutput("t5 in-flight rdata", o_l_rdata, 32'hA2);
    tick();
    @(negedge i_clk);
    checkFlag("t5 l_rvalid cleared", o_l_rvalid, 0);
    checkOutput("t5 l_rdata cleared", o_l_rdata, 32'h0);
    checkFlag("t5 l_ready held rst", o_l_ready, 0);
    tick();
    i_rst_n = 1'b1;
    applyStimulus(1, 0, 10'd5, '0, 0, 0, '0, '0, 0);
    @(negedge i_clk);
    checkFlag("t5 ARB after rst", o_c_ready, 1);
    tick();
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0);
    @(negedge i_clk);
    checkOutput("t5 post rst read", o_c_rdata, 32'hDEADBEEF);
    tick();

    $display("[TB] test 6: random traffic");
    for (int i = 0; i < 16; i++) shadow[i] = initVal(200 + i);
    cPend = 0; lPend = 0; cWe = 0; lWe = 0; lLk = 0;
    cA = '0; lA = '0; cD = '0; lD = '0;
    expCrv = 0; expLrv = 0; expCd = '0; expLd = '0;
    genC = 0; genL = 0; accC = 0; accL = 0; waitC = 0; waitL = 0;
    for (int k = 0; k < 320; k++) begin
      if (!cPend && k < 260 && $urandom_range(0, 2) != 0) begin
        cPend = 1; cWe = 1'($urandom_range(0, 1));
        cA = waddr_t'(200 + $urandom_range(0, 15)); cD = $urandom; genC++; waitC = 0;
      end
      if (!lPend && k < 260 && $urandom_range(0, 2) != 0) begin
        lPend = 1; lWe = 1'($urandom_range(0, 1)); lLk = ($urandom_range(0, 3) == 0);
        lA = waddr_t'(200 + $urandom_range(0, 15)); lD = $urandom; genL++; waitL = 0;
      end
      applyStimulus(cPend, cWe, cA, cD, lPend, lWe, lA, lD, lPend && lLk);
      @(negedge i_clk);
      checkFlag("t6 c_rvalid", o_c_rvalid, expCrv);
      if (expCrv) checkOutput("t6 c_rdata", o_c_rdata, expCd);
      checkFlag("t6 l_rvalid", o_l_rvalid, expLrv);
      if (expLrv) checkOutput("t6 l_rdata", o_l_rdata, expLd);
      checkFlag("t6 one grant", o_c_ready & o_l_ready, 0);
      expCrv = 0;
      expLrv = 0;
      if (o_c_ready) begin
        checkOutput("t6 c m_addr", 32'(o_m_addr), 32'(cA));
        if (cWe) shadow[int'(cA) - 200] = cD;
        else begin expCrv = 1; expCd = shadow[int'(cA) - 200]; end
        accC++; cPend = 0;
      end else if (o_l_ready) begin
        checkOutput("t6 l m_addr", 32'(o_m_addr), 32'(lA));
        if (lWe) shadow[int'(lA) - 200] = lD;
        else begin expLrv = 1; expLd = shadow[int'(lA) - 200]; end
        accL++; lPend = 0;
      end
      if (cPend) waitC++;
      if (lPend) waitL++;
      if (waitC > 40) begin
        total++; bad++; cPend = 0;
        $display("[TB] FAIL t6 cpu wait: waited %0d cycles, required <= 40", waitC);
        waitC = 0;
      end
      if (waitL > 40) begin
        total++; bad++; lPend = 0;
        $display("[TB] FAIL t6 loader wait: waited %0d cycles, required <= 40", waitL);
        waitL = 0;
      end
      tick();
    end
    checkOutput("t6 cpu accepted", accC, genC);
    checkOutput("t6 loader accepted", accL, genL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
